jesd207_burst_sched: RTL

Burst scheduler for the JESD207-style DDR sample path. Two requesters share one transmit burst slot; the block arbitrates round-robin, then drives the dual-edge sample counter's enable (`cnt_en`) and the frame marker for exactly the granted burst length, with a programmable idle gap between bursts. It sits between the channel sources and the DDR sample counter / pad logic.

---
 rtl/jesd207_burst_sched_pkg.sv | 12 +
 rtl/jesd207_burst_sched_rr_arb2.sv | 33 +++
 rtl/jesd207_burst_sched.sv | 132 +++++++++++++
 3 files changed

// File: rtl/jesd207_burst_sched_pkg.sv
// Shared types for the JESD207 burst scheduler: FSM state encoding and channel count.
package jesd207_burst_sched_pkg;

  localparam int unsigned NCH = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/jesd207_burst_sched_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot winner, priority register
// advanced only on an accepted grant.
module rr_arb2
  import jesd207_burst_sched_pkg::*;
(
  input  logic           clk,
  input  logic           rstn,
  input  logic [NCH-1:0] req,
  input  logic           update,
  output logic [NCH-1:0] win_c
);

  // prio=1 means ch1 is favoured when both request
  logic prio;

  always_comb begin
    win_c = NCH'(0);
    if (req[0] && (!req[1] || !prio)) begin
      win_c = NCH'(1);
    end else if (req[1]) begin
      win_c = NCH'(2);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      prio <= 1'b0;
    end else if (update) begin
      prio <= win_c[0];
    end
  end

endmodule

// File: rtl/jesd207_burst_sched.sv
// Burst scheduler: round-robin grant between two requesters, then drives the
// DDR sample counter enable and frame marker for the granted length plus a gap.
module jesd207_burst_sched
  import jesd207_burst_sched_pkg::*;
#(
  parameter int unsigned LEN_W = 8,
  parameter int unsigned GAP   = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NCH-1:0]   req,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic [NCH-1:0]   grant,
  output logic             owner,
  output logic             busy,
  output logic             cnt_en,
  output logic             frame,
  output logic             done
);

  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;

  state_t             state, state_n;
  logic [LEN_W-1:0]   rem, rem_n;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
  logic [NCH-1:0]     win_c, grant_n;
  logic [LEN_W-1:0]   len_sel_c;
  logic               upd_c;
  logic               owner_n, busy_n, cnt_en_n, frame_n, done_n;

  rr_arb2 u_arb (
    .clk    (clk),
    .rstn   (rstn),
    .req    (req),
    .update (upd_c),
    .win_c  (win_c)
  );

  assign len_sel_c = win_c[1] ? len1 : len0;

  // Next state plus next values of every registered output
  always_comb begin
    state_n   = state;
    rem_n     = rem;
    gap_cnt_n = gap_cnt;
    grant_n   = NCH'(0);
    owner_n   = owner;
    busy_n    = 1'b0;
    cnt_en_n  = 1'b0;
    frame_n   = 1'b0;
    done_n    = 1'b0;
    upd_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|req) begin
          upd_c   = 1'b1;
          grant_n = win_c;
          owner_n = win_c[1];
          rem_n   = len_sel_c;
          if (len_sel_c != LEN_W'(0)) begin
            state_n  = ST_BURST;
            busy_n   = 1'b1;
            cnt_en_n = 1'b1;
            frame_n  = 1'b1;
            done_n   = (len_sel_c == LEN_W'(1));
          end else begin
            // zero-length grant: completes immediately, no sample enable
            done_n = 1'b1;
            if (GAP > 0) begin
              state_n   = ST_GAP;
              gap_cnt_n = GAP_W'(GAP);
              busy_n    = 1'b1;
            end
          end
        end
      end
      ST_BURST: begin
        if (rem != LEN_W'(0)) begin
          rem_n = rem - LEN_W'(1);
        end
        if (rem <= LEN_W'(1)) begin
          if (GAP > 0) begin
            state_n   = ST_GAP;
            gap_cnt_n = GAP_W'(GAP);
            busy_n    = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          busy_n   = 1'b1;
          cnt_en_n = 1'b1;
          done_n   = (rem == LEN_W'(2));
        end
      end
      ST_GAP: begin
        if (gap_cnt <= GAP_W'(1)) begin
          state_n = ST_IDLE;
        end else begin
          gap_cnt_n = gap_cnt - GAP_W'(1);
          busy_n    = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      rem     <= LEN_W'(0);
      gap_cnt <= GAP_W'(0);
      grant   <= NCH'(0);
      owner   <= 1'b0;
      busy    <= 1'b0;
      cnt_en  <= 1'b0;
      frame   <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      rem     <= rem_n;
      gap_cnt <= gap_cnt_n;
      grant   <= grant_n;
      owner   <= owner_n;
      busy    <= busy_n;
      cnt_en  <= cnt_en_n;
      frame   <= frame_n;
      done    <= done_n;
    end
  end

endmodule
